// File: rtl/nth_prime_seq.sv
// nth_prime_seq: walks candidates 2,3,5,7,... through an external primality tester
// and reports the n-th prime, with overflow and n==0 flagged through err.
module nth_prime_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] prime_out,
  output logic [31:0]      cycles,
  output logic             tst_start,
  output logic [WIDTH-1:0] tst_value,
  input  logic             tst_result,
  input  logic             tst_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] cand, cnt, n_q;
  logic [WIDTH:0] adv;
  logic accept, hit, last, ovf;
  assign accept = go && (state == IDLE || state == DONE);
  assign hit = state == WAIT && tst_done && tst_result;
  assign last = hit && (cnt + WIDTH'(1)) == n_q;
  // one extra bit so stepping past the top candidate is caught instead of wrapping
  assign adv = {1'b0, cand} + ((cand == WIDTH'(2)) ? (WIDTH+1)'(1) : (WIDTH+1)'(2));
  assign ovf = adv[WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = (n == '0) ? DONE : ISSUE;
      ISSUE:      state_nx = WAIT;
      WAIT:       if (tst_done) state_nx = (last || ovf) ? DONE : ISSUE;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == ISSUE || state == WAIT;
    found = state == DONE;
    tst_start = state == ISSUE;
    tst_value = cand;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt <= '0;
      n_q <= '0;
      prime_out <= '0;
      cycles <= '0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        n_q <= n;
        cand <= WIDTH'(2);
        cnt <= '0;
        cycles <= '0;
        err <= n == '0;
        prime_out <= '0;
      end else if (state == WAIT && tst_done && !last) begin
        if (hit) cnt <= cnt + WIDTH'(1);
        if (ovf) err <= 1'b1;
        else cand <= adv[WIDTH-1:0];
      end
      if (last) prime_out <= cand;
      if (busy && cycles != '1) cycles <= cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_nth_prime_seq.sv
// tb_nth_prime_seq: drives a 32-bit and a 4-bit sequencer against behavioural testers
// and compares results, candidate order and cycle counts with a trial-division model.
module tb_nth_prime_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic go32 = 1'b0, go4 = 1'b0;
  logic [31:0] n32 = '0;
  logic [3:0] n4 = '0;
  logic busy32, found32, err32, start32, done32 = 1'b0, res32 = 1'b0;
  logic [31:0] prime32, cyc32, val32;
  logic busy4, found4, err4, start4, done4 = 1'b0, res4 = 1'b0;
  logic [3:0] prime4, val4;
  logic [31:0] cyc4;
  int passed = 0, total = 0;

  nth_prime_seq #(.WIDTH(32)) d32 (
    .clk(clk), .rst_n(rst_n), .go(go32), .n(n32), .busy(busy32), .found(found32),
    .err(err32), .prime_out(prime32), .cycles(cyc32), .tst_start(start32),
    .tst_value(val32), .tst_result(res32), .tst_done(done32));
  nth_prime_seq #(.WIDTH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .go(go4), .n(n4), .busy(busy4), .found(found4),
    .err(err4), .prime_out(prime4), .cycles(cyc4), .tst_start(start4),
    .tst_value(val4), .tst_result(res4), .tst_done(done4));

  function automatic bit is_prime(input int unsigned v);
    if (v < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // testers: rising start latches value, done drops, answer after 1..3 cycles
  int t32 = 0, t4 = 0;
  int unsigned tv32 = 0, tv4 = 0;
  logic ps32 = 1'b0, ps4 = 1'b0;
  always @(posedge clk) begin
    ps32 <= start32;
    if (start32 && !ps32) begin
      done32 <= 1'b0;
      t32 <= int'($urandom_range(1, 3));
      tv32 <= val32;
    end else if (t32 != 0) begin
      t32 <= t32 - 1;
      if (t32 == 1) begin
        done32 <= 1'b1;
        res32 <= is_prime(tv32);
      end
    end
  end
  always @(posedge clk) begin
    ps4 <= start4;
    if (start4 && !ps4) begin
      done4 <= 1'b0;
      t4 <= int'($urandom_range(1, 3));
      tv4 <= 32'(val4);
    end else if (t4 != 0) begin
      t4 <= t4 - 1;
      if (t4 == 1) begin
        done4 <= 1'b1;
        res4 <= is_prime(tv4);
      end
    end
  end

  // handshake monitor: pulse width, value stability during a test, busy cycles, issued values
  int bc32 = 0, bc4 = 0, wviol = 0, vviol = 0;
  int unsigned q32[$], q4[$];
  logic ls32 = 1'b0, ls4 = 1'b0, lr = 1'b0;
  logic [31:0] lv32 = '0;
  logic [3:0] lv4 = '0;
  always @(negedge clk) begin
    if (busy32) bc32++;
    if (busy4) bc4++;
    if (start32 && !ls32) q32.push_back(val32);
    if (start4 && !ls4) q4.push_back(32'(val4));
    if ((start32 && ls32) || (start4 && ls4)) wviol++;
    if (rst_n && lr && ((t32 != 0 && val32 != lv32) || (t4 != 0 && val4 != lv4))) vviol++;
    ls32 = start32; ls4 = start4; lv32 = val32; lv4 = val4; lr = rst_n;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  int unsigned exp_q[$];
  function automatic void ref_model(input int unsigned nn, input longint unsigned maxv,
                                    output int unsigned p, output bit e);
    longint unsigned c = 2;
    int unsigned k = 0;
    exp_q.delete();
    p = 0;
    e = 1'b1;
    if (nn == 0) return;
    while (1) begin
      exp_q.push_back(int'(c));
      if (is_prime(int'(c))) begin
        k++;
        if (k == nn) begin
          p = int'(c);
          e = 1'b0;
          return;
        end
      end
      c = (c == 2) ? 3 : c + 2;
      if (c > maxv) return;
    end
  endfunction

  task automatic run(input bit s, input int unsigned nn, input bit poke);
    int unsigned ep;
    bit ee, seq_ok;
    int t;
    ref_model(nn, s ? 64'd15 : 64'hFFFF_FFFF, ep, ee);
    @(negedge clk);
    if (s) begin n4 = 4'(nn); go4 = 1'b1; q4.delete(); bc4 = 0; end
    else begin n32 = nn; go32 = 1'b1; q32.delete(); bc32 = 0; end
    @(negedge clk);
    go4 = 1'b0; go32 = 1'b0;
    chk("busy_k1", 64'(s ? busy4 : busy32), 64'(nn != 0));
    chk("start_k1", 64'(s ? start4 : start32), 64'(nn != 0));
    chk("found_k1", 64'(s ? found4 : found32), 64'(nn == 0));
    t = 0;
    while (!(s ? found4 : found32) && t < 60000) begin
      @(negedge clk);
      t++;
      if (poke) begin
        go32 = t >= 4 && t <= 7;
        n32 = $urandom;
      end
    end
    go32 = 1'b0;
    chk("found", 64'(s ? found4 : found32), 64'd1);
    chk("err", 64'(s ? err4 : err32), 64'(ee));
    chk("prime_out", s ? 64'(prime4) : 64'(prime32), 64'(ep));
    chk("pulses", 64'(s ? q4.size() : q32.size()), 64'(exp_q.size()));
    seq_ok = 1'b1;
    foreach (exp_q[i]) if ((s ? q4[i] : q32[i]) != exp_q[i]) seq_ok = 1'b0;
    chk("cand_seq", 64'(seq_ok), 64'd1);
    if (nn != 0) chk("cycles", 64'(s ? cyc4 : cyc32), 64'(s ? bc4 : bc32));
    chk("busy_end", 64'(s ? busy4 : busy32), 64'd0);
    repeat (3) @(negedge clk);
    chk("found_hold", 64'(s ? found4 : found32), 64'd1);
    chk("handshake", 64'(wviol + vviol), 64'd0);
  endtask

  task automatic chk_reset();
    chk("rst_busy", 64'({busy32, busy4}), 64'd0);
    chk("rst_found", 64'({found32, found4}), 64'd0);
    chk("rst_err", 64'({err32, err4}), 64'd0);
    chk("rst_start", 64'({start32, start4}), 64'd0);
    chk("rst_prime", 64'({prime32, prime4}), 64'd0);
    chk("rst_cycles", {cyc32, cyc4}, 64'd0);
    chk("rst_value", 64'({val32, val4}), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    run(0, 1, 0);
    run(0, 6, 0);
    run(0, 0, 0);
    run(1, 7, 0);
    run(1, 6, 0);
    run(1, 0, 0);
    run(0, 1000, 0);
    run(0, 3, 1);
    @(negedge clk);
    n32 = 100; go32 = 1'b1;
    @(negedge clk);
    go32 = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 64'({found32, busy32}), 64'd0);
    run(0, 4, 1);
    repeat (4) run(0, $urandom_range(3, 150), 1'($urandom_range(0, 1)));
    repeat (4) run(1, $urandom_range(0, 15), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/nth_prime_seq.md
# nth_prime_seq

Sequencer that finds the N-th prime by driving the single-candidate primality tester. It sits directly upstream of the tester. It generates candidates 2, 3, 5, 7, 9, … and issues one start pulse per candidate on the tester's `start`/`value` inputs. It then consumes the tester's `done`/`result` and counts primes until the requested index is reached. It is used as the top-level engine for nth-prime style problems, e.g. N=10001.

## Interface
- `WIDTH`, default 32: width of `n`, candidate, prime count and `prime_out`.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `go` input 1: level; sampled only in IDLE or DONE; 1 starts a search.
- `n` input WIDTH: 1-based prime index; captured on the accepted `go`.
- `busy` output 1: 1 from the cycle after `go` is accepted until the search ends.
- `found` output 1: 1 in DONE; held until the next accepted `go` or reset.
- `err` output 1: valid with `found`; 1 means `n`==0 or candidate overflow.
- `prime_out` output WIDTH: N-th prime; valid when `found`=1 and `err`=0, else 0.
- `cycles` output 32: busy-cycle count of the last or current search; saturates at 2^32-1.
- `tst_start` output 1: to tester `start`; one-cycle pulse per candidate.
- `tst_value` output WIDTH: to tester `value`, zero-extended to 32 at integration; stable for the whole test.
- `tst_result` input 1: from tester `result`; meaningful only when `tst_done`=1 in WAIT.
- `tst_done` input 1: from tester `done`.

## Operation
- Reset values (async, `rst_n`=0):
  - state IDLE.
  - `busy`, `found`, `err`, `tst_start` = 0.
  - `prime_out`, `cycles`, `tst_value`, internal count = 0.
- Reset mid-search aborts immediately.
  - The tester is left as is; its next rising `start` edge re-arms it.
- States:
  - IDLE, with `go`=1:
    - If `n`==0: → DONE with `err`=1, `prime_out`=0.
    - Otherwise: capture `n`, set candidate=2, count=0, `cycles`=0, `found`=0, `err`=0, `busy`=1 → ISSUE.
  - ISSUE: drive `tst_start`=1, `tst_value`=candidate for exactly one cycle → WAIT.
  - WAIT: `tst_start`=0.
    - The first WAIT cycle never sees `tst_done`=1, because the tester clears `done` on the start edge.
    - On `tst_done`=1 with `tst_result`=1:
      - If count+1 == `n`: `prime_out`=candidate → DONE.
      - Otherwise: count += 1.
    - If not DONE: advance the candidate (2→3, else +2).
      - If the advance exceeds 2^WIDTH-1: → DONE with `err`=1, `prime_out`=0.
      - Otherwise: → ISSUE.
  - DONE: `found`=1, `busy`=0.
    - `go`=1 restarts exactly as from IDLE; `found` drops in the cycle after acceptance.
- `go` while `busy`=1 is ignored.
- `n` is ignored except on acceptance.
- `cycles` increments on every clock while `busy`=1.
- Arithmetic:
  - Candidate and count are WIDTH-bit.
  - The overflow check uses a WIDTH+1-bit sum; no silent wrap.

## Timing
- Handshake guarantees to the tester:
  - `tst_start` is low for at least one cycle before each rise, so every issue is a clean rising edge.
  - `tst_value` changes only on the clock edge leaving WAIT.
- Per-candidate cost: 1 ISSUE cycle + WAIT cycles up to and including the `tst_done`=1 cycle.
- The next ISSUE follows immediately; there are no idle bubbles.
- `go` accepted at edge k: `busy`=1 and `tst_start`=1 at cycle k+1.
- `n`==0: `found`=1, `err`=1 at cycle k+1, and `busy` never rises.
- `found` and `prime_out` update on the same edge that leaves WAIT.
- `busy` falls on that same edge.

## Test plan
Bench uses the real tester plus a checker on the handshake: `start` pulse width 1, `value` stable while `done`=0.
- `n`=1 → `prime_out`=2, `err`=0, exactly one `tst_start` pulse, `found` held high.
- `n`=6 → `prime_out`=13. Tested values, in order: 2, 3, 5, 7, 9, 11, 13 (7 pulses).
- `n`=0 → `found`=1, `err`=1, `prime_out`=0 one cycle after `go`; no `tst_start` pulse.
- `WIDTH`=4, `n`=7 → candidates run up to 15, then overflow → `err`=1, `prime_out`=0.
- `n`=10001 (WIDTH=32) → `prime_out`=104743; `cycles` equals the busy-cycle count measured by the bench.
- Two back-to-back searches:
  - `go` with `n`=3 → 5.
  - `rst_n` pulse mid-search of `n`=100 → all outputs at reset values.
  - Then `go` with `n`=4 → 7.
  - Pulsing `go` while busy has no effect.
